// File: rtl/dmem_sample_streamer.sv
`default_nettype none
// =============================================================================
// dmem_sample_streamer : walks the sample memory from a base address and emits
// FRAME_LEN-word frames as a valid/ready stream (checksum: DMEM_STREAM_CHECKSUM_EN)
// Revision 1.0 - initial release
// =============================================================================
module dmem_sample_streamer #(
  parameter int AW        = 9,
  parameter int DW        = 16,
  parameter int FRAME_LEN = 20
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [AW-1:0] base_addr,
  input  logic [7:0]    num_frames,
  output logic [AW-1:0] mem_a,
  input  logic [DW-1:0] mem_q,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          m_last,
  output logic          m_eos,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] checksum
);

  localparam int            FW          = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [FW-1:0] C_FRAME_END = FW'(FRAME_LEN - 1);
  localparam logic [15:0]   C_FRAME_LEN = 16'(FRAME_LEN);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_STREAM = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t        r_state, w_next;
  logic [AW-1:0] r_mem_a;
  logic [DW-1:0] r_m_data;
  logic          r_m_valid, r_m_last, r_m_eos, r_busy, r_done;
  logic [15:0]   r_word_cnt, r_total;
  logic [FW-1:0] r_frame_pos;

  logic w_xfer, w_start_acc, w_abort, w_load, w_finish;

  assign w_xfer      = r_m_valid & m_ready;
  assign w_start_acc = (r_state == S_IDLE) & start & ~abort;
  assign w_abort     = abort & (r_state != S_IDLE);
  // Counters hold the index of the word that will be loaded next.
  assign w_load      = ~abort & ((r_state == S_FETCH) |
                                 ((r_state == S_STREAM) & w_xfer & ~r_m_eos));
  assign w_finish    = ~abort & (r_state == S_STREAM) & w_xfer & r_m_eos;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_start_acc) w_next = (num_frames != 8'd0) ? S_FETCH : S_DONE;
      S_FETCH:  w_next = S_STREAM;
      S_STREAM: if (w_finish) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
    if (w_abort) w_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_a     <= '0;
      r_m_data    <= '0;
      r_m_valid   <= 1'b0;
      r_m_last    <= 1'b0;
      r_m_eos     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_word_cnt  <= '0;
      r_total     <= '0;
      r_frame_pos <= '0;
    end else begin
      r_busy <= (w_next == S_FETCH) || (w_next == S_STREAM);
      r_done <= (w_next == S_DONE);
      if (w_start_acc) begin
        r_mem_a     <= base_addr;
        r_word_cnt  <= '0;
        r_frame_pos <= '0;
        r_total     <= 16'(num_frames) * C_FRAME_LEN;
      end else if (w_load) begin
        r_mem_a     <= r_mem_a + AW'(1);
        r_m_data    <= mem_q;
        r_m_valid   <= 1'b1;
        r_m_last    <= (r_frame_pos == C_FRAME_END);
        r_m_eos     <= (r_word_cnt == r_total - 16'd1);
        r_word_cnt  <= r_word_cnt + 16'd1;
        r_frame_pos <= (r_frame_pos == C_FRAME_END) ? '0 : r_frame_pos + FW'(1);
      end else if (w_abort || w_finish) begin
        r_m_valid <= 1'b0;
        r_m_last  <= 1'b0;
        r_m_eos   <= 1'b0;
      end
    end
  end

  assign mem_a   = r_mem_a;
  assign m_data  = r_m_data;
  assign m_valid = r_m_valid;
  assign m_last  = r_m_last;
  assign m_eos   = r_m_eos;
  assign busy    = r_busy;
  assign done    = r_done;

`ifdef DMEM_STREAM_CHECKSUM_EN
  logic [DW-1:0] r_checksum;

  // An abort in the same cycle as a transfer cancels that word's contribution.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                         r_checksum <= '0;
    else if (w_start_acc)                               r_checksum <= '0;
    else if (~abort && (r_state == S_STREAM) && w_xfer) r_checksum <= r_checksum + r_m_data;
  end

  assign checksum = r_checksum;
`else
  assign checksum = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmem_sample_streamer.sv
`default_nettype none
// tb_dmem_sample_streamer : directed self-checking bench for dmem_sample_streamer
// with a behavioural 512 x 16 sample memory.
module tb_dmem_sample_streamer;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, m_ready = 1'b0;
  logic [8:0]  base_addr = '0;
  logic [7:0]  num_frames = '0;
  logic [8:0]  mem_a;
  logic [15:0] mem_q, m_data, checksum;
  logic        m_valid, m_last, m_eos, busy, done;

  logic [15:0] mem [512];
  int n_checks = 0, n_fail = 0;

  logic [15:0] cap_data [$];
  logic        cap_last [$];
  logic        cap_eos  [$];
  logic [8:0]  cap_a    [$];
  int first_valid, last_xfer, done_cyc, done_cnt, unstable;

  assign mem_q = mem[mem_a];
  always #5 clk = ~clk;

  dmem_sample_streamer #(.AW(9), .DW(16), .FRAME_LEN(20)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .base_addr(base_addr), .num_frames(num_frames),
    .mem_a(mem_a), .mem_q(mem_q),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .m_eos(m_eos),
    .busy(busy), .done(done), .checksum(checksum)
  );

  // Expected checksum over n words starting at b (address wraps modulo 512).
  function automatic logic [15:0] exp_sum(input logic [8:0] b, input int n);
    logic [15:0] s;
    s = '0;
    for (int k = 0; k < n; k++) s = s + mem[9'(int'(b) + k)];
`ifdef DMEM_STREAM_CHECKSUM_EN
    return s;
`else
    return 16'h0000;
`endif
  endfunction

  task automatic do_start(input logic [8:0] b, input logic [7:0] n);
    @(posedge clk); #1;
    base_addr = b; num_frames = n; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // mode 0: m_ready always 1; mode 1: m_ready pattern 1,0,0,1.
  // inj: cycle at which a stray start (base 100, 3 frames) is pulsed, -1 = none.
  task automatic capture(input int mode, input int max_cyc, input int inj);
    logic        stalled, pl, pe;
    logic [15:0] pd;
    logic [8:0]  pa;
    stalled = 1'b0; pl = 1'b0; pe = 1'b0; pd = '0; pa = '0;
    cap_data.delete(); cap_last.delete(); cap_eos.delete(); cap_a.delete();
    first_valid = -1; last_xfer = -1; done_cyc = -1; done_cnt = 0; unstable = 0;
    for (int c = 0; c < max_cyc; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (c == inj) begin start = 1'b1; base_addr = 9'd100; num_frames = 8'd3; end
      if (done) begin done_cnt++; if (done_cyc < 0) done_cyc = c; end
      if (m_valid && first_valid < 0) first_valid = c;
      if (stalled && m_valid && ({m_data, m_last, m_eos, mem_a} !== {pd, pl, pe, pa})) unstable++;
      m_ready = (mode == 0) ? 1'b1 : ((c % 4 == 0) || (c % 4 == 3));
      if (m_valid && m_ready) begin
        cap_data.push_back(m_data); cap_last.push_back(m_last);
        cap_eos.push_back(m_eos);   cap_a.push_back(mem_a);
        last_xfer = c;
      end
      stalled = m_valid && !m_ready;
      {pd, pl, pe, pa} = {m_data, m_last, m_eos, mem_a};
      if (done_cyc >= 0 && c >= done_cyc + 2) break;
    end
    m_ready = 1'b0; start = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_checks++;
    if ({m_valid, m_last, m_eos, busy, done} !== 5'b0 || mem_a !== 9'd0 ||
        m_data !== 16'd0 || checksum !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v%b l%b e%b b%b d%b a=%0d data=%h cs=%h, expected all zero",
               m_valid, m_last, m_eos, busy, done, mem_a, m_data, checksum);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_basic();
    do_start(9'd0, 8'd1);
    n_checks++;
    if (m_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL basic_fetch: got valid=%b busy=%b, expected 0/1", m_valid, busy);
    end
    capture(0, 60, -1);
    n_checks++;
    if (first_valid !== 0) begin
      n_fail++; $display("FAIL basic_latency: got cycle %0d, expected 0", first_valid);
    end
    n_checks++;
    if (cap_data.size() !== 20) begin
      n_fail++; $display("FAIL basic_count: got %0d, expected 20", cap_data.size());
    end
    for (int k = 0; k < cap_data.size(); k++) begin
      n_checks++;
      if (cap_data[k] !== mem[k] || cap_last[k] !== (k == 19) || cap_eos[k] !== (k == 19) ||
          cap_a[k] !== 9'(k + 1)) begin
        n_fail++;
        $display("FAIL basic_word%0d: got d=%h l=%b e=%b a=%0d, expected d=%h l=%b e=%b a=%0d",
                 k, cap_data[k], cap_last[k], cap_eos[k], cap_a[k], mem[k], (k == 19), (k == 19), k + 1);
      end
    end
    n_checks++;
    if (done_cnt !== 1 || done_cyc !== last_xfer + 1) begin
      n_fail++; $display("FAIL basic_done: got %0d pulses at cycle %0d, expected 1 at %0d",
                         done_cnt, done_cyc, last_xfer + 1);
    end
    n_checks++;
    if (checksum !== exp_sum(9'd0, 20) || busy !== 1'b0) begin
      n_fail++; $display("FAIL basic_checksum: got %h busy=%b, expected %h busy=0",
                         checksum, busy, exp_sum(9'd0, 20));
    end
  endtask

  task automatic test_wrap();
    do_start(9'd510, 8'd1);
    capture(0, 60, -1);
    n_checks++;
    if (cap_data.size() !== 20) begin
      n_fail++; $display("FAIL wrap_count: got %0d, expected 20", cap_data.size());
    end
    for (int k = 0; k < cap_data.size(); k++) begin
      n_checks++;
      if (cap_data[k] !== mem[9'(510 + k)] || cap_a[k] !== 9'(511 + k)) begin
        n_fail++;
        $display("FAIL wrap_word%0d: got d=%h a=%0d, expected d=%h a=%0d",
                 k, cap_data[k], cap_a[k], mem[9'(510 + k)], 9'(511 + k));
      end
    end
    n_checks++;
    if (checksum !== exp_sum(9'd510, 20) || done_cnt !== 1) begin
      n_fail++; $display("FAIL wrap_end: got cs=%h done=%0d, expected cs=%h done=1",
                         checksum, done_cnt, exp_sum(9'd510, 20));
    end
  endtask

  task automatic test_backpressure();
    do_start(9'd0, 8'd2);
    capture(1, 200, 10);
    n_checks++;
    if (cap_data.size() !== 40 || unstable !== 0) begin
      n_fail++; $display("FAIL bp_count: got %0d words, %0d unstable stalls, expected 40 and 0",
                         cap_data.size(), unstable);
    end
    for (int k = 0; k < cap_data.size(); k++) begin
      n_checks++;
      if (cap_data[k] !== mem[k] || cap_last[k] !== (k == 19 || k == 39) ||
          cap_eos[k] !== (k == 39)) begin
        n_fail++;
        $display("FAIL bp_word%0d: got d=%h l=%b e=%b, expected d=%h l=%b e=%b",
                 k, cap_data[k], cap_last[k], cap_eos[k], mem[k], (k == 19 || k == 39), (k == 39));
      end
    end
    n_checks++;
    if (checksum !== exp_sum(9'd0, 40) || done_cnt !== 1) begin
      n_fail++; $display("FAIL bp_end: got cs=%h done=%0d, expected cs=%h done=1",
                         checksum, done_cnt, exp_sum(9'd0, 40));
    end
  endtask

  task automatic test_zero_length();
    int   dcnt, dfirst;
    logic bseen, vseen;
    dcnt = 0; dfirst = -1; bseen = 1'b0; vseen = 1'b0;
    do_start(9'd5, 8'd0);
    for (int c = 0; c < 5; c++) begin
      if (done) begin dcnt++; if (dfirst < 0) dfirst = c; end
      bseen = bseen | busy; vseen = vseen | m_valid;
      @(posedge clk); #1;
    end
    n_checks++;
    if (dcnt !== 1 || dfirst > 1 || dfirst < 0) begin
      n_fail++; $display("FAIL zero_done: got %0d pulses first at %0d, expected 1 at 0..1", dcnt, dfirst);
    end
    n_checks++;
    if (bseen !== 1'b0 || vseen !== 1'b0) begin
      n_fail++; $display("FAIL zero_idle: got busy_seen=%b valid_seen=%b, expected 0/0", bseen, vseen);
    end
  endtask

  task automatic test_abort();
    int dcnt;
    dcnt = 0;
    m_ready = 1'b1;
    do_start(9'd0, 8'd1);
    repeat (8) @(posedge clk);
    #1;
    m_ready = 1'b0; abort = 1'b1;
    n_checks++;
    if (m_valid !== 1'b1 || m_data !== mem[7]) begin
      n_fail++; $display("FAIL abort_word7: got v=%b d=%h, expected v=1 d=%h", m_valid, m_data, mem[7]);
    end
    @(posedge clk); #1;
    abort = 1'b0;
    n_checks++;
    if (m_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL abort_stop: got v=%b busy=%b done=%b, expected 0/0/0", m_valid, busy, done);
    end
    for (int c = 0; c < 4; c++) begin
      if (done || m_valid) dcnt++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (dcnt !== 0 || checksum !== exp_sum(9'd0, 7)) begin
      n_fail++; $display("FAIL abort_after: got activity=%0d cs=%h, expected 0 cs=%h",
                         dcnt, checksum, exp_sum(9'd0, 7));
    end
    do_start(9'd0, 8'd1);
    capture(0, 60, -1);
    n_checks++;
    if (cap_data.size() !== 20 || cap_data[0] !== mem[0] || checksum !== exp_sum(9'd0, 20)) begin
      n_fail++; $display("FAIL abort_restart: got %0d words first=%h cs=%h, expected 20 first=%h cs=%h",
                         cap_data.size(), (cap_data.size() > 0) ? cap_data[0] : 16'hxxxx,
                         checksum, mem[0], exp_sum(9'd0, 20));
    end
  endtask

  task automatic test_reset_mid_stream();
    m_ready = 1'b1;
    do_start(9'd0, 8'd2);
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({m_valid, m_last, m_eos, busy, done} !== 5'b0 || mem_a !== 9'd0 ||
        m_data !== 16'd0 || checksum !== 16'd0) begin
      n_fail++;
      $display("FAIL midrst_outputs: got v%b l%b e%b b%b d%b a=%0d data=%h cs=%h, expected all zero",
               m_valid, m_last, m_eos, busy, done, mem_a, m_data, checksum);
    end
    m_ready = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    do_start(9'd0, 8'd1);
    capture(0, 60, -1);
    n_checks++;
    if (first_valid !== 0 || cap_data.size() !== 20 || cap_data[0] !== mem[0] ||
        cap_eos[19] !== 1'b1 || done_cnt !== 1 || checksum !== exp_sum(9'd0, 20)) begin
      n_fail++; $display("FAIL midrst_restart: got fv=%0d words=%0d done=%0d cs=%h, expected 0/20/1 cs=%h",
                         first_valid, cap_data.size(), done_cnt, checksum, exp_sum(9'd0, 20));
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 16'(i * 305 + 66);
    mem[0]   = 16'h7FFF; mem[1]   = 16'h0C88; mem[2] = 16'h1897;
    mem[18]  = 16'h8000; mem[19]  = 16'h0000;
    mem[510] = 16'h0336; mem[511] = 16'hF378;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero_length();
    test_abort();
    test_reset_mid_stream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
